// File: rtl/sfr_arbiter_if.sv
// Request/ack bundle between the CPU, timer 0, serial port, the SFR file and the arbiter.
// The arbiter uses the slave view; requesters and the SFR file model use the master view.
interface sfr_arbiter_if;
    logic       i_cpu_req;
    logic       i_cpu_we;
    logic       i_cpu_bit;
    logic [7:0] i_cpu_addr;
    logic [7:0] i_cpu_wdata;
    logic [2:0] i_cpu_bitsel;
    logic       i_cpu_bitval;
    logic       o_cpu_ack;
    logic       o_cpu_err;
    logic [7:0] o_cpu_rdata;

    logic       i_tmr_req;
    logic [7:0] i_tmr_addr;
    logic [7:0] i_tmr_wdata;
    logic       o_tmr_ack;

    logic       i_ser_req;
    logic [7:0] i_ser_addr;
    logic [7:0] i_ser_wdata;
    logic       o_ser_ack;

    logic [7:0] o_sfr_addr;
    logic [7:0] o_sfr_wdata;
    logic       o_sfr_we;
    logic [7:0] i_sfr_rdata;

    logic       o_busy;

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_bit, i_cpu_addr, i_cpu_wdata, i_cpu_bitsel, i_cpu_bitval,
        output o_cpu_ack, o_cpu_err, o_cpu_rdata,
        input  i_tmr_req, i_tmr_addr, i_tmr_wdata,
        output o_tmr_ack,
        input  i_ser_req, i_ser_addr, i_ser_wdata,
        output o_ser_ack,
        output o_sfr_addr, o_sfr_wdata, o_sfr_we,
        input  i_sfr_rdata,
        output o_busy
    );

    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_bit, i_cpu_addr, i_cpu_wdata, i_cpu_bitsel, i_cpu_bitval,
        input  o_cpu_ack, o_cpu_err, o_cpu_rdata,
        output i_tmr_req, i_tmr_addr, i_tmr_wdata,
        input  o_tmr_ack,
        output i_ser_req, i_ser_addr, i_ser_wdata,
        input  o_ser_ack,
        input  o_sfr_addr, o_sfr_wdata, o_sfr_we,
        output i_sfr_rdata,
        input  o_busy
    );
endinterface

// File: rtl/sfr_arbiter.sv
// SFR port arbiter (CPU / timer 0 / serial) with starvation guard; ack 2 cycles after grant edge
// for byte accesses, 3 for bit read-modify-write; requesters hold req until their one-cycle ack.
module sfr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic           i_clk,
    input logic           i_rst,
    sfr_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RMW_RD = 2'd2, RMW_WR = 2'd3} state_t;
    typedef enum logic [1:0] {SRC_CPU = 2'd0, SRC_TMR = 2'd1, SRC_SER = 2'd2} src_t;

    typedef struct packed {
        src_t       src;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       we;
        logic       bit_op;
        logic [2:0] bitsel;
        logic       bitval;
        logic       err;
    } xact_t;

    state_t     state, state_nxt;
    xact_t      xact, xact_nxt;
    src_t       win;
    logic       cpu_elig, tmr_elig, ser_elig, any_elig;
    logic       tmr_starved, ser_starved;
    logic [3:0] tmr_cnt, ser_cnt;
    logic       rr_ser;
    logic [7:0] rmw_byte, rmw_merged;
    logic       cpu_ack, tmr_ack, ser_ack, cpu_err;
    logic [7:0] cpu_rdata;
    logic [7:0] sfr_addr, sfr_wdata;
    logic       sfr_we, busy, done;

    // A requester still showing its ack is only holding a stale request.
    always_comb begin
        cpu_elig    = bus.i_cpu_req & ~cpu_ack;
        tmr_elig    = bus.i_tmr_req & ~tmr_ack;
        ser_elig    = bus.i_ser_req & ~ser_ack;
        any_elig    = cpu_elig | tmr_elig | ser_elig;
        tmr_starved = tmr_elig && (tmr_cnt == LIMIT);
        ser_starved = ser_elig && (ser_cnt == LIMIT);
        win         = SRC_CPU;
        if (tmr_starved && ser_starved) win = rr_ser ? SRC_SER : SRC_TMR;
        else if (tmr_starved)           win = SRC_TMR;
        else if (ser_starved)           win = SRC_SER;
        else if (cpu_elig)              win = SRC_CPU;
        else if (tmr_elig && ser_elig)  win = rr_ser ? SRC_SER : SRC_TMR;
        else if (tmr_elig)              win = SRC_TMR;
        else if (ser_elig)              win = SRC_SER;
    end

    always_comb begin
        xact_nxt     = '0;
        xact_nxt.src = win;
        case (win)
            SRC_CPU: begin
                xact_nxt.addr   = bus.i_cpu_addr;
                xact_nxt.wdata  = bus.i_cpu_wdata;
                xact_nxt.bit_op = bus.i_cpu_bit;
                xact_nxt.we     = bus.i_cpu_we & ~bus.i_cpu_bit;
                xact_nxt.bitsel = bus.i_cpu_bitsel;
                xact_nxt.bitval = bus.i_cpu_bitval;
                // Only bit-addressable SFRs (address multiple of 8) accept bit operations.
                xact_nxt.err    = bus.i_cpu_bit && (bus.i_cpu_addr[2:0] != 3'd0);
            end
            SRC_TMR: begin
                xact_nxt.addr  = bus.i_tmr_addr;
                xact_nxt.wdata = bus.i_tmr_wdata;
                xact_nxt.we    = 1'b1;
            end
            SRC_SER: begin
                xact_nxt.addr  = bus.i_ser_addr;
                xact_nxt.wdata = bus.i_ser_wdata;
                xact_nxt.we    = 1'b1;
            end
            default: xact_nxt.src = SRC_CPU;
        endcase
    end

    always_comb begin
        rmw_merged                = rmw_byte;
        rmw_merged[xact.bitsel]   = xact.bitval;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sfr_addr  = 8'h00;
        sfr_wdata = 8'h00;
        sfr_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_elig)
                    state_nxt = (xact_nxt.bit_op && !xact_nxt.err) ? RMW_RD : XFER;
            end
            XFER: begin
                sfr_addr  = xact.addr;
                sfr_we    = xact.we;
                sfr_wdata = xact.we ? xact.wdata : 8'h00;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            RMW_RD: begin
                sfr_addr  = xact.addr;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                sfr_addr  = xact.addr;
                sfr_we    = 1'b1;
                sfr_wdata = rmw_merged;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            xact      <= '0;
            tmr_cnt   <= 4'd0;
            ser_cnt   <= 4'd0;
            rr_ser    <= 1'b0;
            rmw_byte  <= 8'h00;
            cpu_ack   <= 1'b0;
            tmr_ack   <= 1'b0;
            ser_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 8'h00;
        end else begin
            cpu_ack <= 1'b0;
            tmr_ack <= 1'b0;
            ser_ack <= 1'b0;
            cpu_err <= 1'b0;
            if (state == IDLE && any_elig) begin
                xact <= xact_nxt;
                if (win == SRC_TMR)                     tmr_cnt <= 4'd0;
                else if (tmr_elig && tmr_cnt != LIMIT)  tmr_cnt <= tmr_cnt + 4'd1;
                if (win == SRC_SER)                     ser_cnt <= 4'd0;
                else if (ser_elig && ser_cnt != LIMIT)  ser_cnt <= ser_cnt + 4'd1;
                if (win == SRC_TMR)      rr_ser <= 1'b1;
                else if (win == SRC_SER) rr_ser <= 1'b0;
            end
            if (state == RMW_RD) rmw_byte <= bus.i_sfr_rdata;
            if (done) begin
                cpu_ack <= (xact.src == SRC_CPU);
                tmr_ack <= (xact.src == SRC_TMR);
                ser_ack <= (xact.src == SRC_SER);
                cpu_err <= (xact.src == SRC_CPU) && xact.err;
                if (state == XFER && xact.src == SRC_CPU && !xact.we && !xact.bit_op)
                    cpu_rdata <= bus.i_sfr_rdata;
            end
        end
    end

    assign bus.o_cpu_ack   = cpu_ack;
    assign bus.o_tmr_ack   = tmr_ack;
    assign bus.o_ser_ack   = ser_ack;
    assign bus.o_cpu_err   = cpu_err;
    assign bus.o_cpu_rdata = cpu_rdata;
    assign bus.o_sfr_addr  = sfr_addr;
    assign bus.o_sfr_wdata = sfr_wdata;
    assign bus.o_sfr_we    = sfr_we;
    assign bus.o_busy      = busy;

endmodule

// File: tb/tb_sfr_arbiter.sv
// Directed bench for sfr_arbiter: SFR file model plus an ack scoreboard fed at request time.
module tb_sfr_arbiter;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   wr_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] mem [256];

    typedef struct {
        int         id;
        logic       err;
        logic       chk_rd;
        logic [7:0] rdata;
        int         lat;
        int         t0;
    } exp_t;
    exp_t sb[$];

    sfr_arbiter_if bus ();

    sfr_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.i_sfr_rdata = mem[bus.o_sfr_addr];
    always @(posedge clk) begin
        if (bus.o_sfr_we) begin
            mem[bus.o_sfr_addr] <= bus.o_sfr_wdata;
            wr_cnt              <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every ack pops the oldest expectation and is compared against it.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   id;
        if (rst && (bus.o_cpu_ack || bus.o_tmr_ack || bus.o_ser_ack)) begin
            chk("one_ack", 32'(bus.o_cpu_ack) + 32'(bus.o_tmr_ack) + 32'(bus.o_ser_ack), 1);
            chk("busy_in_ack_cycle", 32'(bus.o_busy), 0);
            id = bus.o_cpu_ack ? 0 : (bus.o_tmr_ack ? 1 : 2);
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_ack: got ack from id %0d, expected no ack", id);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("grant_id", id, e.id);
                if (e.id == 0) chk("cpu_err", 32'(bus.o_cpu_err), 32'(e.err));
                if (e.chk_rd) chk("cpu_rdata", 32'(bus.o_cpu_rdata), 32'(e.rdata));
                if (e.lat != 0) chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic wait_ack(input int which, input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = (which == 0) ? bus.o_cpu_ack : ((which == 1) ? bus.o_tmr_ack : bus.o_ser_ack);
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout: got no ack in 20 cycles, expected one", tag);
        end
    endtask

    task automatic cpu_op(input logic we, input logic bop, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [2:0] bsel, input logic bval,
                          input logic exp_err, input logic chk_rd, input logic [7:0] exp_rd,
                          input int lat, input string tag);
        @(negedge clk);
        bus.i_cpu_we     = we;
        bus.i_cpu_bit    = bop;
        bus.i_cpu_addr   = addr;
        bus.i_cpu_wdata  = wdata;
        bus.i_cpu_bitsel = bsel;
        bus.i_cpu_bitval = bval;
        bus.i_cpu_req    = 1'b1;
        sb.push_back('{0, exp_err, chk_rd, exp_rd, lat, cyc});
        wait_ack(0, tag);
        bus.i_cpu_req = 1'b0;
    endtask

    task automatic periph_write(input int which, input logic [7:0] addr, input logic [7:0] wdata,
                                input string tag);
        @(negedge clk);
        if (which == 1) begin
            bus.i_tmr_addr = addr; bus.i_tmr_wdata = wdata; bus.i_tmr_req = 1'b1;
        end else begin
            bus.i_ser_addr = addr; bus.i_ser_wdata = wdata; bus.i_ser_req = 1'b1;
        end
        sb.push_back('{which, 1'b0, 1'b0, 8'h00, 2, cyc});
        wait_ack(which, tag);
        bus.i_tmr_req = 1'b0;
        bus.i_ser_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        bus.i_cpu_req = 1'b0;
        bus.i_tmr_req = 1'b0;
        bus.i_ser_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Requests stay up until the queued grant order has been seen; with cpu_mode the
    // timer steps back only while the CPU holds its ack.
    task automatic run_stream(input logic cpu_mode, input string tag);
        for (int k = 0; k < 200 && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
            if (cpu_mode) bus.i_tmr_req = !bus.o_cpu_ack;
        end
        bus.i_cpu_req = 1'b0;
        bus.i_tmr_req = 1'b0;
        bus.i_ser_req = 1'b0;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: got %0d grants outstanding, expected 0", tag, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        int w0;
        rst              = 1'b0;
        bus.i_cpu_req    = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_bit = 1'b0;
        bus.i_cpu_addr   = 8'h00; bus.i_cpu_wdata = 8'h00;
        bus.i_cpu_bitsel = 3'd0; bus.i_cpu_bitval = 1'b0;
        bus.i_tmr_req    = 1'b0; bus.i_tmr_addr = 8'h00; bus.i_tmr_wdata = 8'h00;
        bus.i_ser_req    = 1'b0; bus.i_ser_addr = 8'h00; bus.i_ser_wdata = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(bus.o_busy), 0);
        chk("rst_we",    32'(bus.o_sfr_we), 0);
        chk("rst_addr",  32'(bus.o_sfr_addr), 0);
        chk("rst_wdata", 32'(bus.o_sfr_wdata), 0);
        chk("rst_rdata", 32'(bus.o_cpu_rdata), 0);
        chk("rst_acks",  32'({bus.o_cpu_ack, bus.o_tmr_ack, bus.o_ser_ack, bus.o_cpu_err}), 0);
        rst = 1'b1;

        // Byte write 0x55 -> 0xE0 with a look inside the XFER cycle.
        @(negedge clk);
        w0 = wr_cnt;
        bus.i_cpu_we = 1'b1; bus.i_cpu_bit = 1'b0; bus.i_cpu_addr = 8'hE0; bus.i_cpu_wdata = 8'h55;
        bus.i_cpu_req = 1'b1;
        sb.push_back('{0, 1'b0, 1'b0, 8'h00, 2, cyc});
        @(posedge clk);
        #1;
        chk("xfer_busy",  32'(bus.o_busy), 1);
        chk("xfer_we",    32'(bus.o_sfr_we), 1);
        chk("xfer_addr",  32'(bus.o_sfr_addr), 32'h00E0);
        chk("xfer_wdata", 32'(bus.o_sfr_wdata), 32'h0055);
        wait_ack(0, "wr_e0");
        bus.i_cpu_req = 1'b0;
        chk("ack_cycle_we",   32'(bus.o_sfr_we), 0);
        chk("ack_cycle_addr", 32'(bus.o_sfr_addr), 0);
        chk("wr_e0_count", wr_cnt - w0, 1);
        chk("mem_e0", 32'(mem[8'hE0]), 32'h55);

        cpu_op(1'b0, 1'b0, 8'hE0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 8'h55, 2, "rd_e0");

        // Bit operations on 0xD0 holding 0x81.
        cpu_op(1'b1, 1'b0, 8'hD0, 8'h81, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2, "wr_d0");
        cpu_op(1'b0, 1'b1, 8'hD0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 3, "setb_d0");
        chk("mem_d0_setb", 32'(mem[8'hD0]), 32'h89);
        cpu_op(1'b1, 1'b1, 8'hD0, 8'hFF, 3'd7, 1'b0, 1'b0, 1'b0, 8'h00, 3, "clr_d0");
        chk("mem_d0_clr", 32'(mem[8'hD0]), 32'h09);

        // Bit op on a non bit-addressable SFR: error, no write, read data untouched.
        w0 = wr_cnt;
        cpu_op(1'b1, 1'b1, 8'h81, 8'hFF, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 2, "bit_81");
        chk("bit_81_no_write", wr_cnt - w0, 0);
        chk("rdata_held", 32'(bus.o_cpu_rdata), 32'h55);

        periph_write(1, 8'h8C, 8'h3C, "tmr_wr");
        chk("mem_8c", 32'(mem[8'h8C]), 32'h3C);
        periph_write(2, 8'h99, 8'hA5, "ser_wr");
        chk("mem_99", 32'(mem[8'h99]), 32'hA5);

        // Timer and serial both continuous: strict alternation starting with the timer.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) sb.push_back('{(k % 2 == 0) ? 1 : 2, 1'b0, 1'b0, 8'h00, 0, 0});
        bus.i_tmr_addr = 8'h8C; bus.i_tmr_wdata = 8'h11; bus.i_tmr_req = 1'b1;
        bus.i_ser_addr = 8'h99; bus.i_ser_wdata = 8'h22; bus.i_ser_req = 1'b1;
        run_stream(1'b0, "tmr_ser_rr");

        // CPU and timer both pending: four CPU wins, then the starved timer, then the CPU again.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) sb.push_back('{(k == 4) ? 1 : 0, 1'b0, 1'b0, 8'h00, 0, 0});
        bus.i_cpu_we = 1'b1; bus.i_cpu_bit = 1'b0; bus.i_cpu_addr = 8'h90; bus.i_cpu_wdata = 8'h77;
        bus.i_cpu_req = 1'b1;
        bus.i_tmr_req = 1'b1;
        run_stream(1'b1, "cpu_starve");

        // Reset while in RMW_RD drops the transaction outright.
        cpu_op(1'b1, 1'b0, 8'hA8, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2, "wr_a8");
        w0 = wr_cnt;
        @(negedge clk);
        bus.i_cpu_we = 1'b0; bus.i_cpu_bit = 1'b1; bus.i_cpu_addr = 8'hA8;
        bus.i_cpu_bitsel = 3'd0; bus.i_cpu_bitval = 1'b1; bus.i_cpu_req = 1'b1;
        @(posedge clk);
        #1;
        chk("rmw_rd_busy", 32'(bus.o_busy), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.o_busy), 0);
        chk("mid_rst_we",   32'(bus.o_sfr_we), 0);
        chk("mid_rst_ack",  32'(bus.o_cpu_ack), 0);
        bus.i_cpu_req = 1'b0;
        bus.i_cpu_bit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_no_write", wr_cnt - w0, 0);
        chk("mem_a8_kept", 32'(mem[8'hA8]), 0);
        chk("mid_rst_rdata", 32'(bus.o_cpu_rdata), 0);
        cpu_op(1'b0, 1'b0, 8'hE0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 8'h55, 2, "rd_after_rst");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
